mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2, giving the RAM read latency in cycles (legal range 1..8).
REQ-002 SHALL have parameter MAX_CONSEC, default 3, giving the number of consecutive data grants allowed while fetch waits (legal range 1..7).
REQ-003 SHALL have the following ports: reset is synchronous, active-low; clock is clock.
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low
- halt  in  1  blocks new grants; an in-flight access completes
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  16  fetch address
- if_ready  out  1  one-cycle fetch-complete pulse
- if_rdata  out  16  fetch data, valid when if_ready
- d_req  in  1  data request, held until d_ready
- d_we  in  1  data write enable, qualifies d_req
- d_addr  in  16  data address
- d_wdata  in  16  data write value
- d_ready  out  1  one-cycle data-complete pulse
- d_rdata  out  16  load data, valid when d_ready (0 on writes)
- ram_en  out  1  single-port RAM access strobe
- ram_we  out  1  RAM write strobe
- ram_addr  out  16  RAM address
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data
- if_stall  out  1  if_req & ~if_ready
- d_stall  out  1  d_req & ~d_ready
- busy  out  1  high in every state except IDLE

Function
REQ-004 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, DONE.
REQ-005 SHALL arbitrate only in IDLE; with halt=0 and any request present at cycle T, it SHALL enter ISSUE at T+1; otherwise it SHALL remain in IDLE.
REQ-006 SHALL grant data over fetch when both request, unless the starvation count equals MAX_CONSEC, in which case fetch SHALL win.
REQ-007 Starvation count (3 bits) SHALL increment on a data grant with if_req=1, SHALL clear on a data grant with if_req=0, and SHALL clear on every fetch grant.
REQ-008 SHALL register the address, write enable and write data of the granted requester at the grant edge; ram_en SHALL be high only in ISSUE, with ram_we=d_we for data grants and 0 for fetch grants.
REQ-009 SHALL load a latency counter with LATENCY on entering ISSUE and decrement it each cycle in ISSUE/WAIT; ISSUE→WAIT when LATENCY>1, else ISSUE→DONE; WAIT→DONE when the counter reaches 1.
REQ-010 SHALL capture ram_rdata into the granted requester's rdata register at the last ISSUE/WAIT cycle (cycle T+LATENCY) for reads; for writes it SHALL load 0.
REQ-011 SHALL assert exactly one of if_ready/d_ready in DONE (cycle T+LATENCY+1), then return to IDLE; DONE SHALL NOT arbitrate.
REQ-012 if_rdata/d_rdata SHALL hold their last value until the next completion for that requester.
REQ-013 A request dropped before ready SHALL NOT abort the access; the access completes and ready pulses regardless.
REQ-014 halt SHALL be ignored outside IDLE; halt=1 in IDLE SHALL hold IDLE with ram_en=0.

Reset
REQ-015 reset=0 at a rising edge SHALL force IDLE, latency and starvation counters to 0, ram_en=ram_we=0, ram_addr=ram_wdata=0, if_ready=d_ready=0, and if_rdata=d_rdata=0, discarding any in-flight access without a ready pulse.
REQ-016 The first grant SHALL be possible in the cycle after reset deasserts.

Verification
REQ-017 LATENCY=2; if_req=1, if_addr=0x0010 at T, RAM returns 0xBEEF at T+2 -> ram_en=1 at T+1 only, if_ready=1, if_rdata=0xBEEF at T+3.
REQ-018 d_req=1, d_we=1, d_addr=0x0020, d_wdata=0x1234 and if_req=1 together at T -> data granted, ram_we=1 at T+1, d_ready at T+3, d_rdata=0; fetch granted at T+4.
REQ-019 MAX_CONSEC=3; if_req and d_req held continuously -> grant order D,D,D,I,D,D,D,I.
REQ-020 LATENCY=1; single fetch at T -> ISSUE at T+1, DONE at T+2, WAIT never entered.
REQ-021 halt=1 with both requests pending -> ram_en stays 0, busy=0; halt raised during WAIT -> access completes with a ready pulse.
REQ-022 reset=0 applied in WAIT -> next cycle IDLE, no ready pulse, all outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port RAM between a fetch port (if_*) and a data port
//   (d_*). Data has priority, but fetch is guaranteed a grant after
//   MAX_CONSEC consecutive data grants taken while fetch was waiting.
//   Each access walks IDLE -> ISSUE -> (WAIT ...) -> DONE -> IDLE and
//   returns its read data LATENCY cycles after the grant decision.
//
// Ports
//   clock, reset        rising-edge clock; synchronous active-low reset
//   halt                blocks new grants (in-flight access still completes)
//   if_req/if_addr      fetch request; if_ready pulse + if_rdata on completion
//   d_req/d_we/d_addr/d_wdata
//                       data request; d_ready pulse + d_rdata on completion
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata
//                       single-port RAM interface
//   if_stall/d_stall    requester is waiting for its ready pulse
//   busy                an access is in progress
module mem_port_arbiter #(
  parameter int LATENCY    = 2,
  parameter int MAX_CONSEC = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ready,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic [15:0] d_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        if_stall,
  output logic        d_stall,
  output logic        busy
);

  localparam logic [3:0] LAT_INIT  = 4'(LATENCY);
  localparam logic [2:0] STARVE_MAX = 3'(MAX_CONSEC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [3:0]  lat_cnt;
  logic [2:0]  starve_cnt;
  logic        grant_data;   // owner of the access in flight: 1 = data, 0 = fetch
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] if_rdata_q;
  logic [15:0] d_rdata_q;

  logic grant;
  logic pick_data;
  logic last_cycle;

  // Data wins ties unless fetch has already been passed over MAX_CONSEC times.
  assign pick_data = d_req && !(if_req && (starve_cnt == STARVE_MAX));
  assign grant     = (state == IDLE) && !halt && (if_req || d_req);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    last_cycle = 1'b0;
    case (state)
      IDLE: begin
        if (grant) state_next = ISSUE;
      end
      ISSUE: begin
        if (LATENCY > 1) begin
          state_next = WAIT;
        end else begin
          state_next = DONE;
          last_cycle = 1'b1;
        end
      end
      WAIT: begin
        if (lat_cnt == 4'd1) begin
          state_next = DONE;
          last_cycle = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      grant_data <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= state_next;

      if (grant) begin
        lat_cnt    <= LAT_INIT;
        grant_data <= pick_data;
        we_q       <= pick_data && d_we;
        addr_q     <= pick_data ? d_addr : if_addr;
        wdata_q    <= pick_data ? d_wdata : 16'h0000;
        if (pick_data && if_req) starve_cnt <= starve_cnt + 3'd1;
        else                     starve_cnt <= '0;
      end else if (state == ISSUE || state == WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end

      // RAM data is valid in the final ISSUE/WAIT cycle; writes report zero.
      if (last_cycle) begin
        if (grant_data) d_rdata_q  <= we_q ? 16'h0000 : ram_rdata;
        else            if_rdata_q <= ram_rdata;
      end
    end
  end

  assign ram_en    = (state == ISSUE);
  assign ram_we    = ram_en && we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign if_ready  = (state == DONE) && !grant_data;
  assign d_ready   = (state == DONE) &&  grant_data;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign if_stall  = if_req && !if_ready;
  assign d_stall   = d_req  && !d_ready;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance dut uses LATENCY=2,
// MAX_CONSEC=3; instance dut1 uses LATENCY=1. Each has a small RAM model
// that only presents valid read data in the cycle the arbiter must sample
// it; any other cycle it returns 16'hDEAD.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        halt;

  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_ready, d_ready, ram_en, ram_we, if_stall, d_stall, busy;
  logic [15:0] if_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;

  logic        if1_req;
  logic [15:0] if1_addr;
  logic        d1_req, d1_we;
  logic [15:0] d1_addr, d1_wdata;
  logic        if1_ready, d1_ready, ram1_en, ram1_we, if1_stall, d1_stall, busy1;
  logic [15:0] if1_rdata, d1_rdata, ram1_addr, ram1_wdata, ram1_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.LATENCY(2), .MAX_CONSEC(3)) dut (
    .clock(clock), .reset(reset), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .if_stall(if_stall), .d_stall(d_stall), .busy(busy)
  );

  mem_port_arbiter #(.LATENCY(1), .MAX_CONSEC(3)) dut1 (
    .clock(clock), .reset(reset), .halt(halt),
    .if_req(if1_req), .if_addr(if1_addr), .if_ready(if1_ready), .if_rdata(if1_rdata),
    .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
    .d_ready(d1_ready), .d_rdata(d1_rdata),
    .ram_en(ram1_en), .ram_we(ram1_we), .ram_addr(ram1_addr),
    .ram_wdata(ram1_wdata), .ram_rdata(ram1_rdata),
    .if_stall(if1_stall), .d_stall(d1_stall), .busy(busy1)
  );

  // RAM contents: 0x0010 holds 0xBEEF, every other word holds addr ^ 0x5A5A.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Two-cycle RAM: data appears the cycle after the read strobe.
  logic        rd_v_q = 1'b0;
  logic [15:0] rd_a_q = '0;
  always @(posedge clock) begin
    rd_v_q <= ram_en && !ram_we;
    rd_a_q <= ram_addr;
  end
  assign ram_rdata  = rd_v_q ? mem_word(rd_a_q) : 16'hDEAD;

  // One-cycle RAM: data appears in the strobe cycle itself.
  assign ram1_rdata = (ram1_en && !ram1_we) ? mem_word(ram1_addr) : 16'hDEAD;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [15:0] order [8];
  logic [15:0] exp_order [8];
  int          n_grants;

  initial begin
    reset = 1'b0; halt = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if1_req = 1'b0; if1_addr = '0; d1_req = 1'b0; d1_we = 1'b0; d1_addr = '0; d1_wdata = '0;
    for (int i = 0; i < 8; i++) order[i] = '0;

    // ---- reset state ----
    @(negedge clock);
    tick();
    tick();
    check("rst_busy",      {15'd0, busy},     16'h0000);
    check("rst_ram_en",    {15'd0, ram_en},   16'h0000);
    check("rst_ram_addr",  ram_addr,          16'h0000);
    check("rst_if_rdata",  if_rdata,          16'h0000);
    check("rst_d_rdata",   d_rdata,           16'h0000);

    // ---- first grant right after reset; fetch read with LATENCY=2 ----
    reset = 1'b1; if_req = 1'b1; if_addr = 16'h0010;
    tick();   // T+1
    check("f_issue_en",    {15'd0, ram_en},   16'h0001);
    check("f_issue_we",    {15'd0, ram_we},   16'h0000);
    check("f_issue_addr",  ram_addr,          16'h0010);
    tick();   // T+2
    check("f_wait_en",     {15'd0, ram_en},   16'h0000);
    check("f_wait_busy",   {15'd0, busy},     16'h0001);
    check("f_wait_stall",  {15'd0, if_stall}, 16'h0001);
    check("f_wait_ready",  {15'd0, if_ready}, 16'h0000);
    tick();   // T+3
    check("f_done_ready",  {15'd0, if_ready}, 16'h0001);
    check("f_done_dready", {15'd0, d_ready},  16'h0000);
    check("f_done_rdata",  if_rdata,          16'hBEEF);
    check("f_done_stall",  {15'd0, if_stall}, 16'h0000);
    if_req = 1'b0;
    tick();   // T+4
    check("f_idle_busy",   {15'd0, busy},     16'h0000);
    check("f_idle_ready",  {15'd0, if_ready}, 16'h0000);

    // ---- lone data read ----
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0044;
    tick();
    check("dr_issue_addr", ram_addr,          16'h0044);
    tick();
    tick();
    check("dr_done_ready", {15'd0, d_ready},  16'h0001);
    check("dr_rdata",      d_rdata,           16'h5A1E);
    check("dr_if_hold",    if_rdata,          16'hBEEF);
    d_req = 1'b0;
    tick();

    // ---- data write and fetch together: data wins, fetch follows ----
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    if_req = 1'b1; if_addr = 16'h0030;
    tick();   // T+1
    check("dw_issue_we",   {15'd0, ram_we},   16'h0001);
    check("dw_issue_addr", ram_addr,          16'h0020);
    check("dw_issue_wd",   ram_wdata,         16'h1234);
    tick();   // T+2
    check("dw_wait_we",    {15'd0, ram_we},   16'h0000);
    tick();   // T+3
    check("dw_done_ready", {15'd0, d_ready},  16'h0001);
    check("dw_done_iready",{15'd0, if_ready}, 16'h0000);
    check("dw_rdata_zero", d_rdata,           16'h0000);
    d_req = 1'b0; d_we = 1'b0;
    tick();   // T+4: IDLE, fetch granted here
    check("dw_t4_en",      {15'd0, ram_en},   16'h0000);
    tick();   // T+5
    check("fi_issue_en",   {15'd0, ram_en},   16'h0001);
    check("fi_issue_addr", ram_addr,          16'h0030);
    check("fi_issue_we",   {15'd0, ram_we},   16'h0000);
    tick();
    tick();   // T+7
    check("fi_done_ready", {15'd0, if_ready}, 16'h0001);
    check("fi_rdata",      if_rdata,          16'h5A6A);
    check("fi_d_hold",     d_rdata,           16'h0000);
    if_req = 1'b0;
    tick();

    // ---- starvation limit: both held, expect D,D,D,I,D,D,D,I ----
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0D00;
    if_req = 1'b1; if_addr = 16'h0100;
    exp_order = '{16'h0D00, 16'h0D00, 16'h0D00, 16'h0100,
                  16'h0D00, 16'h0D00, 16'h0D00, 16'h0100};
    n_grants = 0;
    for (int c = 0; c < 60 && n_grants < 8; c++) begin
      tick();
      if (ram_en) begin
        order[n_grants] = ram_addr;
        n_grants++;
      end
    end
    for (int i = 0; i < 8; i++) check($sformatf("order_%0d", i), order[i], exp_order[i]);
    d_req = 1'b0; if_req = 1'b0;
    tick();
    tick();
    tick();
    check("st_idle_busy",  {15'd0, busy},     16'h0000);

    // ---- halt in IDLE blocks grants; halt during WAIT is ignored ----
    halt = 1'b1; d_req = 1'b1; if_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("halt_en_%0d", c),   {15'd0, ram_en}, 16'h0000);
      check($sformatf("halt_busy_%0d", c), {15'd0, busy},   16'h0000);
    end
    halt = 1'b0;
    tick();   // ISSUE
    check("h_issue_en",    {15'd0, ram_en},   16'h0001);
    check("h_issue_addr",  ram_addr,          16'h0D00);
    tick();   // WAIT
    halt = 1'b1;
    tick();   // DONE
    check("h_done_dready", {15'd0, d_ready},  16'h0001);
    check("h_done_iready", {15'd0, if_ready}, 16'h0000);
    d_req = 1'b0; if_req = 1'b0;
    tick();
    check("h_idle_busy",   {15'd0, busy},     16'h0000);
    halt = 1'b0;
    tick();

    // ---- reset in WAIT discards the access ----
    if_req = 1'b1; if_addr = 16'h0200;
    tick();   // ISSUE
    check("r_issue_en",    {15'd0, ram_en},   16'h0001);
    tick();   // WAIT
    reset = 1'b0;
    tick();
    check("r_busy",        {15'd0, busy},     16'h0000);
    check("r_if_ready",    {15'd0, if_ready}, 16'h0000);
    check("r_d_ready",     {15'd0, d_ready},  16'h0000);
    check("r_ram_en",      {15'd0, ram_en},   16'h0000);
    check("r_ram_addr",    ram_addr,          16'h0000);
    check("r_if_rdata",    if_rdata,          16'h0000);
    check("r_d_rdata",     d_rdata,           16'h0000);
    reset = 1'b1; if_req = 1'b0;
    tick();
    check("r_after_ready", {15'd0, if_ready}, 16'h0000);
    check("r_after_busy",  {15'd0, busy},     16'h0000);

    // ---- LATENCY=1 fetch: ISSUE then DONE, no WAIT ----
    if1_req = 1'b1; if1_addr = 16'h0077;
    tick();   // T+1
    check("l1_issue_en",   {15'd0, ram1_en},   16'h0001);
    check("l1_issue_rdy",  {15'd0, if1_ready}, 16'h0000);
    tick();   // T+2
    check("l1_done_ready", {15'd0, if1_ready}, 16'h0001);
    check("l1_done_en",    {15'd0, ram1_en},   16'h0000);
    check("l1_rdata",      if1_rdata,          16'h5A2D);
    if1_req = 1'b0;
    tick();   // T+3
    check("l1_idle_busy",  {15'd0, busy1},     16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
